icebreaker_alu: RTL and testbench
=================================

# icebreaker_alu

UART-driven 32-bit ALU top level for the iCEBreaker board. It receives command packets over a 115200-baud 8N1 serial link, accumulates big-endian 32-bit operands, and returns a 4-byte big-endian result or an echo of the payload. It contains the board PLL, the `uart_rx`/`uart_tx` byte links, and the packet/ALU state machine.

## Interface
- `BAUD_RATE`, default 115200: serial bit rate.
- `CLK_FREQ_HZ`, default 20275200: core clock frequency, the PLL output.
- `CLK` input, 1: 12 MHz board clock. It feeds the PLL instance `pll`, whose `PLLOUTGLOBAL` (20.2752 MHz) is the single core clock for all logic.
- `BTN_N` input, 1: reset. Asynchronous, active-high; all core state is cleared while it is 1.
- `RX` input, 1: serial data in from the host; idles high.
- `TX` output, 1: serial data out to the host; idles high.
- `LEDG_N` output, 1: active-low busy LED.

## Operation
- Prescale is CLK_FREQ_HZ/(BAUD_RATE·8) = 22, so one bit lasts 176 core clocks. Frames are 8N1, LSB first. Both `uart_rx` and `uart_tx` use AXI-stream byte handshakes.
- Packet format, in order:
  - opcode byte
  - reserved byte, ignored
  - length LSB, then length MSB; length is the total packet byte count including the 4-byte header
  - payload of (length−4) bytes, taken as 32-bit words MSB first
- Opcodes:
  - 0xEC echo: each payload byte is retransmitted unchanged, in order.
  - 0xA0 add: sum of all words, mod 2^32.
  - 0xA1 mul: low 32 bits of the product of all words.
  - Any other opcode: the packet is consumed and nothing is transmitted.
- For add/mul, the first word loads the accumulator and each later word is combined into it. With zero words the result is 0x00000000.
- Add/mul respond with exactly 4 bytes, MSB first.
- A length below 4 is treated as 4. A trailing partial word (length−4 not a multiple of 4) is consumed and ignored.
- Bytes with a frame error are discarded and do not advance the FSM.
- FSM states: OPCODE → RSVD → LEN_LO → LEN_HI, then DATA or SKIP (unknown opcode), then RESP for add/mul, then back to OPCODE. Echo stays in DATA, forwarding each byte to TX.
- Header-only packets go from LEN_HI straight to RESP (add/mul) or OPCODE (echo, unknown).
- The rx-side `tready` is deasserted during RESP. The host must wait for the full response before sending again; bytes arriving meanwhile are lost as overrun.
- Reset values: `TX`=1, `LEDG_N`=1, FSM=OPCODE, accumulator=0, byte counters=0. Reset mid-packet or mid-response aborts at once and `TX` returns high.

## Timing
- Each received byte is accepted on the cycle `m_axis_tvalid` is high; the FSM advances on that edge.
- The accumulator updates on the clock after the 4th byte of each word. Multiply is single-cycle.
- The first response byte is offered to `uart_tx` 2 cycles after the last payload byte is accepted. Each following byte is offered when `s_axis_tready` returns high, with no idle gap beyond the stop bit.
- Each byte occupies 10 bits × 176 = 1760 cycles on the wire.
- `LEDG_N` is 0 from opcode acceptance until the last response byte has been handed to `uart_tx`; otherwise it is 1.

## Configuration
- `ICEBREAKER_ALU_MUL_EN`:
  - Defined: opcode 0xA1 and the 32×32 multiplier are compiled in.
  - Undefined: 0xA1 is treated as an unknown opcode (consumed, no response) and no multiplier logic exists.

## Structure
- Shared package `icebreaker_alu_pkg` holds:
  - opcode constants: OP_ECHO=0xEC, OP_ADD=0xA0, OP_MUL=0xA1
  - FSM state enum
  - `BAUD_RATE`/`CLK_FREQ_HZ` defaults and the prescale constant
  - header length constant (4)
- One natural sub-module, `icebreaker_alu_core`: the packet FSM plus accumulator, sitting between the rx and tx AXI streams.
- The top level holds only the PLL, the UART instances, and LED/reset wiring.

## Test plan
- Reset: pulse `BTN_N`=1 for one cycle → `TX`=1, `LEDG_N`=1, no receive activity for 10000 cycles.
- Add: A0 00 0C 00, then 00000005, 00000007 → response bytes 00 00 00 0C.
- Add wrap: A0 00 0C 00, then FFFFFFFF, 00000002 → response 00 00 00 01.
- Mul (macro defined): A1 00 0C 00, then 00010000, 00010003 → response 00 03 00 00.
- Echo: EC 00 08 00, then DEADBEEF → response bytes DE AD BE EF.
- Unknown opcode: 55 00 08 00, then 12345678, followed by the add packet above → only 00 00 00 0C is received.

Source files
------------

// File: rtl/icebreaker_alu_pkg.sv
// Shared constants, opcodes and packet FSM states for the UART-driven ALU.
// ICEBREAKER_ALU_MUL_EN adds the multiply opcode to the set of computing opcodes.
package icebreaker_alu_pkg;

  localparam int BAUD_RATE_DFLT = 115200;
  localparam int CLK_FREQ_DFLT  = 20275200;
  localparam int PRESCALE_DFLT  = CLK_FREQ_DFLT / (BAUD_RATE_DFLT * 8);

  localparam logic [15:0] HDR_LEN = 16'd4;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;

  typedef enum logic [2:0] {
    ST_OPCODE,
    ST_RSVD,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_SKIP,
    ST_RESP
  } state_e;

  // Opcodes that fold payload words into the accumulator and answer with 4 bytes.
  function automatic logic is_calc_op(input logic [7:0] op);
`ifdef ICEBREAKER_ALU_MUL_EN
    return (op == OP_ADD) || (op == OP_MUL);
`else
    return op == OP_ADD;
`endif
  endfunction

endpackage

// File: rtl/icebreaker_alu_core.sv
// Packet FSM and 32-bit accumulator between the rx and tx byte streams.
// ICEBREAKER_ALU_MUL_EN compiles in the 0xA1 multiply path.
module icebreaker_alu_core
  import icebreaker_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_tdata,
  input  logic       rx_tvalid,
  output logic       rx_tready,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic       busy
);

  state_e      state;
  logic [7:0]  op, len_lo;
  logic [15:0] remain, cnt, pkt_len;
  logic [31:0] word, acc;
  logic        word_rdy, first_word, resp_wait;
  logic [1:0]  resp_idx;
  logic        rx_fire, last_byte, word_end;

  // Hold off rx while a response is being sent or a byte is still waiting for the transmitter.
  assign rx_tready = (state != ST_RESP) && !tx_tvalid;
  assign rx_fire   = rx_tvalid && rx_tready;
  assign pkt_len   = {rx_tdata, len_lo};
  assign last_byte = (cnt == remain - 16'd1);
  assign word_end  = (cnt[1:0] == 2'd3) && (cnt < {remain[15:2], 2'b00});
  assign busy      = (state != ST_OPCODE) || tx_tvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OPCODE;
      op         <= 8'd0;
      len_lo     <= 8'd0;
      remain     <= 16'd0;
      cnt        <= 16'd0;
      word       <= 32'd0;
      acc        <= 32'd0;
      word_rdy   <= 1'b0;
      first_word <= 1'b0;
      resp_wait  <= 1'b0;
      resp_idx   <= 2'd0;
      tx_tdata   <= 8'd0;
      tx_tvalid  <= 1'b0;
    end else begin
      if (tx_tvalid && tx_tready) tx_tvalid <= 1'b0;

      if (word_rdy) begin
        word_rdy   <= 1'b0;
        first_word <= 1'b0;
        if (first_word) acc <= word;
`ifdef ICEBREAKER_ALU_MUL_EN
        else if (op == OP_MUL) acc <= acc * word;
`endif
        else acc <= acc + word;
      end

      case (state)
        ST_OPCODE: if (rx_fire) begin
          op         <= rx_tdata;
          acc        <= 32'd0;
          first_word <= 1'b1;
          cnt        <= 16'd0;
          state      <= ST_RSVD;
        end
        ST_RSVD: if (rx_fire) state <= ST_LEN_LO;
        ST_LEN_LO: if (rx_fire) begin
          len_lo <= rx_tdata;
          state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (rx_fire) begin
          remain    <= (pkt_len > HDR_LEN) ? pkt_len - HDR_LEN : 16'd0;
          resp_wait <= 1'b1;
          resp_idx  <= 2'd0;
          if (pkt_len <= HDR_LEN) state <= is_calc_op(op) ? ST_RESP : ST_OPCODE;
          else if (is_calc_op(op) || op == OP_ECHO) state <= ST_DATA;
          else state <= ST_SKIP;
        end
        ST_DATA: if (rx_fire) begin
          cnt <= cnt + 16'd1;
          if (op == OP_ECHO) begin
            tx_tdata  <= rx_tdata;
            tx_tvalid <= 1'b1;
          end else begin
            word <= {word[23:0], rx_tdata};
            if (word_end) word_rdy <= 1'b1;
          end
          if (last_byte) state <= (op == OP_ECHO) ? ST_OPCODE : ST_RESP;
        end
        ST_SKIP: if (rx_fire) begin
          cnt <= cnt + 16'd1;
          if (last_byte) state <= ST_OPCODE;
        end
        ST_RESP: begin
          // One spare cycle lets the final word land in the accumulator before byte 0 is taken.
          if (resp_wait) begin
            resp_wait <= 1'b0;
          end else if (tx_tvalid) begin
            if (tx_tready) begin
              resp_idx <= resp_idx + 2'd1;
              if (resp_idx == 2'd3) state <= ST_OPCODE;
            end
          end else begin
            tx_tdata  <= 8'(acc >> {~resp_idx, 3'b000});
            tx_tvalid <= 1'b1;
          end
        end
        default: state <= ST_OPCODE;
      endcase
    end
  end

endmodule

// File: rtl/icebreaker_alu_pll.sv
// Clock-generation boundary: 12 MHz board clock in, core clock out on PLLOUTGLOBAL.
// The behavioural body is a pass-through; the iCE40 build binds the SB_PLL40_PAD primitive here.
module icebreaker_alu_pll (
  input  logic PACKAGEPIN,
  output logic PLLOUTGLOBAL
);

  assign PLLOUTGLOBAL = PACKAGEPIN;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with an AXI-stream byte output; PRESCALE*8 clocks per bit.
// Frame errors and bytes arriving while the output is still held are dropped.
module uart_rx #(
  parameter int PRESCALE = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready
);

  localparam int BIT_CYC = PRESCALE * 8;
  localparam int CW      = $clog2(BIT_CYC);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);

  logic [2:0]    sync;
  logic          busy;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync          <= 3'b111;
      busy          <= 1'b0;
      bit_idx       <= 4'd0;
      cnt           <= '0;
      shreg         <= 8'd0;
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
    end else begin
      sync <= {sync[1:0], rxd};
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      if (!busy) begin
        // Arm only on a falling edge so a line held low after a bad frame is not re-read.
        if (sync[2] && !sync[1]) begin
          busy    <= 1'b1;
          bit_idx <= 4'd0;
          cnt     <= HALF;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= FULL;
        if (bit_idx == 4'd0) begin
          if (sync[1]) busy <= 1'b0;
          else bit_idx <= 4'd1;
        end else if (bit_idx < 4'd9) begin
          shreg   <= {sync[1], shreg[7:1]};
          bit_idx <= bit_idx + 4'd1;
        end else begin
          busy <= 1'b0;
          if (sync[1] && !(m_axis_tvalid && !m_axis_tready)) begin
            m_axis_tdata  <= shreg;
            m_axis_tvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with an AXI-stream byte input; PRESCALE*8 clocks per bit.
module uart_tx #(
  parameter int PRESCALE = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       txd
);

  localparam int BIT_CYC = PRESCALE * 8;
  localparam int CW      = $clog2(BIT_CYC);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);

  logic [8:0]    shreg;
  logic [3:0]    bits_left;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd           <= 1'b1;
      s_axis_tready <= 1'b0;
      shreg         <= 9'h1FF;
      bits_left     <= 4'd0;
      cnt           <= '0;
    end else if (bits_left == 4'd0) begin
      if (s_axis_tvalid && s_axis_tready) begin
        txd           <= 1'b0;
        shreg         <= {1'b1, s_axis_tdata};
        bits_left     <= 4'd10;
        cnt           <= FULL;
        s_axis_tready <= 1'b0;
      end else begin
        s_axis_tready <= 1'b1;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      // bits_left==1 marks the end of the stop bit; the line simply stays high.
      cnt       <= FULL;
      bits_left <= bits_left - 4'd1;
      if (bits_left != 4'd1) begin
        txd   <= shreg[0];
        shreg <= {1'b1, shreg[8:1]};
      end
    end
  end

endmodule

// File: rtl/icebreaker_alu.sv
// iCEBreaker top: PLL, UART byte links and the packet/ALU core; BTN_N is an active-high reset.
// Multiply support is selected by ICEBREAKER_ALU_MUL_EN.
module icebreaker_alu
  import icebreaker_alu_pkg::*;
#(
  parameter int BAUD_RATE   = BAUD_RATE_DFLT,
  parameter int CLK_FREQ_HZ = CLK_FREQ_DFLT
) (
  input  logic CLK,
  input  logic BTN_N,
  input  logic RX,
  output logic TX,
  output logic LEDG_N
);

  localparam int PRESCALE = CLK_FREQ_HZ / (BAUD_RATE * 8);

  logic       clk, rst, busy;
  logic [7:0] rx_tdata, tx_tdata;
  logic       rx_tvalid, rx_tready, tx_tvalid, tx_tready;

  icebreaker_alu_pll pll (
    .PACKAGEPIN  (CLK),
    .PLLOUTGLOBAL(clk)
  );

  assign rst = BTN_N;

  uart_rx #(.PRESCALE(PRESCALE)) u_uart_rx (
    .clk          (clk),
    .rst          (rst),
    .rxd          (RX),
    .m_axis_tdata (rx_tdata),
    .m_axis_tvalid(rx_tvalid),
    .m_axis_tready(rx_tready)
  );

  icebreaker_alu_core u_core (
    .clk      (clk),
    .rst      (rst),
    .rx_tdata (rx_tdata),
    .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready),
    .tx_tdata (tx_tdata),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .busy     (busy)
  );

  uart_tx #(.PRESCALE(PRESCALE)) u_uart_tx (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (tx_tdata),
    .s_axis_tvalid(tx_tvalid),
    .s_axis_tready(tx_tready),
    .txd          (TX)
  );

  assign LEDG_N = ~busy;

endmodule

// File: tb/tb_icebreaker_alu.sv
// Serial-level bench for icebreaker_alu: directed packet table, corner sequences, random packets.
// The DUT runs at 16 clocks per bit so the run stays short.
module tb_icebreaker_alu;

  localparam int BIT = 16;

`ifdef ICEBREAKER_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef logic [7:0] u8;

  typedef struct {
    string        name;
    logic [255:0] pkt;
    int           plen;
    logic [31:0]  rsp;
    int           rlen;
  } vec_t;

  logic CLK = 1'b0;
  logic BTN_N = 1'b1;
  logic RX = 1'b1;
  logic TX, LEDG_N;

  int vectors = 0;
  int miscompares = 0;
  u8  got_q[$];

  icebreaker_alu #(.BAUD_RATE(1267200), .CLK_FREQ_HZ(20275200)) dut (
    .CLK   (CLK),
    .BTN_N (BTN_N),
    .RX    (RX),
    .TX    (TX),
    .LEDG_N(LEDG_N)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial decoder for TX, sampling mid-bit on the falling clock edge.
  initial begin : tx_monitor
    u8 b;
    forever begin
      @(negedge CLK);
      if (!BTN_N && TX === 1'b0) begin
        repeat (BIT / 2) @(negedge CLK);
        if (TX === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge CLK);
            b[i] = TX;
          end
          repeat (BIT) @(negedge CLK);
          got_q.push_back(b);
        end
      end
    end
  end

  task automatic send_byte(input u8 b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      RX = f[i];
      repeat (BIT - 1) @(negedge CLK);
    end
    RX = 1'b1;
  endtask

  // Reference: responses derived from the packet rules with plain arithmetic.
  function automatic void model(input u8 pkt[$], output u8 rsp[$]);
    int len, nw;
    logic [31:0] res, w;
    bit is_add, is_mul;
    rsp = {};
    len = int'({pkt[3], pkt[2]});
    if (len < 4) len = 4;
    is_add = (pkt[0] == 8'hA0);
    is_mul = (pkt[0] == 8'hA1) && MUL_EN;
    if (pkt[0] == 8'hEC) begin
      for (int i = 4; i < len; i++) rsp.push_back(pkt[i]);
    end else if (is_add || is_mul) begin
      nw  = (len - 4) / 4;
      res = is_add ? 32'd0 : 32'd1;
      for (int k = 0; k < nw; k++) begin
        w = {pkt[4+4*k], pkt[5+4*k], pkt[6+4*k], pkt[7+4*k]};
        res = is_add ? res + w : res * w;
      end
      if (nw == 0) res = 32'd0;
      for (int i = 3; i >= 0; i--) rsp.push_back(u8'(res >> (8 * i)));
    end
  endfunction

  task automatic collect(input string name, input u8 exp[$]);
    int budget;
    budget = (exp.size() + 2) * BIT * 12 + 200;
    while (got_q.size() < exp.size() && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    repeat (BIT * 14) @(negedge CLK);
    check({name, " count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("%s byte%0d", name, i), got_q[i], exp[i]);
    check({name, " led idle"}, LEDG_N, 1'b1);
  endtask

  task automatic run_packet(input string name, input u8 pkt[$], input u8 exp[$]);
    got_q.delete();
    foreach (pkt[i]) send_byte(pkt[i], 1'b1);
    collect(name, exp);
  endtask

  vec_t tbl[$];
  u8    pq[$], eq[$];
  u8    op;
  int   n, budget;

  initial begin
    tbl.push_back('{name:"add",        pkt:{96'hA0000C00_00000005_00000007, 160'h0}, plen:12, rsp:32'h0000000C, rlen:4});
    tbl.push_back('{name:"add_wrap",   pkt:{96'hA0000C00_FFFFFFFF_00000002, 160'h0}, plen:12, rsp:32'h00000001, rlen:4});
    tbl.push_back('{name:"mul",        pkt:{96'hA1000C00_00010000_00010003, 160'h0}, plen:12, rsp:32'h00030000, rlen:MUL_EN ? 4 : 0});
    tbl.push_back('{name:"echo",       pkt:{64'hEC000800_DEADBEEF, 192'h0},          plen:8,  rsp:32'hDEADBEEF, rlen:4});
    tbl.push_back('{name:"unknown",    pkt:{160'h55000800_12345678_A0000C00_00000005_00000007, 96'h0}, plen:20, rsp:32'h0000000C, rlen:4});
    tbl.push_back('{name:"hdr_only",   pkt:{32'hA0000400, 224'h0},                    plen:4,  rsp:32'h00000000, rlen:4});
    tbl.push_back('{name:"short_len",  pkt:{32'hA0000200, 224'h0},                    plen:4,  rsp:32'h00000000, rlen:4});
    tbl.push_back('{name:"partial",    pkt:{80'hA0000A00_00000003_AABB, 176'h0},      plen:10, rsp:32'h00000003, rlen:4});

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst tx", TX, 1'b1);
    check("rst led", LEDG_N, 1'b1);
    BTN_N = 1'b0;
    repeat (2000) @(negedge CLK);
    check("idle rx bytes", got_q.size(), 0);
    check("idle tx", TX, 1'b1);

    foreach (tbl[v]) begin
      pq = {};
      eq = {};
      for (int i = 0; i < tbl[v].plen; i++) pq.push_back(tbl[v].pkt[255 - 8*i -: 8]);
      for (int i = 0; i < tbl[v].rlen; i++) eq.push_back(tbl[v].rsp[31 - 8*i -: 8]);
      run_packet(tbl[v].name, pq, eq);
    end

    // A framing-error byte in the middle of a header must not advance the FSM.
    got_q.delete();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h77, 1'b0);
    repeat (BIT * 3) @(negedge CLK);
    pq = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
    foreach (pq[i]) send_byte(pq[i], 1'b1);
    eq = '{8'h00, 8'h00, 8'h00, 8'h0C};
    collect("frame_err", eq);

    // Reset during a response aborts it and the next packet is handled normally.
    got_q.delete();
    pq = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
    foreach (pq[i]) send_byte(pq[i], 1'b1);
    budget = 400;
    while (TX !== 1'b0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    check("resp started", TX, 1'b0);
    repeat (BIT * 3) @(negedge CLK);
    check("led busy in resp", LEDG_N, 1'b0);
    BTN_N = 1'b1;
    @(negedge CLK);
    check("abort tx high", TX, 1'b1);
    check("abort led", LEDG_N, 1'b1);
    BTN_N = 1'b0;
    repeat (BIT * 24) @(negedge CLK);
    eq = '{8'h00, 8'h00, 8'h00, 8'h0C};
    run_packet("after_abort", pq, eq);

    // Random packets against the reference model.
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 3))
        0: op = 8'hA0;
        1: op = 8'hA1;
        2: op = 8'hEC;
        default: begin
          op = u8'($urandom_range(0, 255));
          while (op == 8'hA0 || op == 8'hA1 || op == 8'hEC) op = u8'($urandom_range(0, 255));
        end
      endcase
      n  = $urandom_range(0, 13);
      pq = {};
      pq.push_back(op);
      pq.push_back(u8'($urandom_range(0, 255)));
      if (n == 0 && $urandom_range(0, 1) == 1) pq.push_back(u8'($urandom_range(0, 3)));
      else pq.push_back(u8'(n + 4));
      pq.push_back(8'h00);
      for (int i = 0; i < n; i++) pq.push_back(u8'($urandom_range(0, 255)));
      model(pq, eq);
      run_packet($sformatf("rand%0d op%0h n%0d", r, op, n), pq, eq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
